random_source: RTL

- Seeded PRNG that feeds fresh randomness words to the zero-sharing stage and other masked gadgets in the masked AES-128 datapath.
- Uses a 64-bit xorshift64 state with a seed-load handshake, a warm-up phase and a per-cycle advance enable.
- Output words are the low bits of the state register, so the output is glitch-free and registered.

---
 rtl/random_source_pkg.sv | 33 +++
 rtl/random_source.sv | 102 ++++++++++
 2 files changed

// File: rtl/random_source_pkg.sv
// random_source_pkg
//   Shared types and the xorshift64 step used by the randomness source that
//   feeds the zero-sharing stage and other masked gadgets of the masked
//   AES-128 datapath.
//   Contents:
//     fsm_t              - controller states (unseeded / warming up / running)
//     prng_state_t       - 64-bit generator state
//     SHIFT_A/B/C        - xorshift64 shift amounts (13, 7, 17)
//     xorshift64_step()  - one generator step on a 64-bit state
package random_source_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } fsm_t;

    typedef logic [63:0] prng_state_t;

    localparam int unsigned SHIFT_A = 13;
    localparam int unsigned SHIFT_B = 7;
    localparam int unsigned SHIFT_C = 17;

    // Bits shifted out of the 64-bit word are dropped at every stage.
    function automatic prng_state_t xorshift64_step(input prng_state_t x);
        prng_state_t y;
        y = x ^ (x << SHIFT_A);
        y = y ^ (y >> SHIFT_B);
        y = y ^ (y << SHIFT_C);
        return y;
    endfunction

endpackage

// File: rtl/random_source.sv
// random_source
//   Seeded xorshift64 PRNG delivering NUM_OUT words of BIT_WIDTH bits per
//   cycle. Each seed load is followed by WARMUP_CYCLES discarded steps before
//   out_valid is raised. Output words are the low bits of the state register,
//   so they are registered and glitch-free.
//   Ports:
//     in_clock        rising-edge clock
//     in_reset        synchronous active-high reset
//     in_seed         64-bit seed value
//     in_seed_valid   seed offered
//     out_seed_ready  seed can be accepted this cycle (IDLE or RUN)
//     in_enable       consumer takes the current words; state advances in RUN
//     out_random      packed words, word i = [i*BIT_WIDTH +: BIT_WIDTH]
//     out_valid       out_random holds a post-warm-up value
module random_source
    import random_source_pkg::*;
#(
    parameter int NUM_OUT       = 2,
    parameter int BIT_WIDTH     = 2,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic                           in_clock,
    input  logic                           in_reset,
    input  logic [63:0]                    in_seed,
    input  logic                           in_seed_valid,
    output logic                           out_seed_ready,
    input  logic                           in_enable,
    output logic [NUM_OUT*BIT_WIDTH-1:0]   out_random,
    output logic                           out_valid
);

    localparam int OUT_W = NUM_OUT * BIT_WIDTH;
    localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

    if (OUT_W > 64 || WARMUP_CYCLES < 1) begin : g_bad_params
        $error("random_source: NUM_OUT*BIT_WIDTH must be <= 64 and WARMUP_CYCLES >= 1");
    end

    fsm_t              fsm;
    fsm_t              fsm_next;
    prng_state_t       state;
    logic [CNT_W-1:0]  counter;
    logic              seed_accept;

    assign seed_accept = in_seed_valid && out_seed_ready;
    assign out_random  = state[OUT_W-1:0];

    // FSM state register
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (seed_accept) fsm_next = WARMUP;
            WARMUP:  if (counter == CNT_W'(1)) fsm_next = RUN;
            RUN:     if (seed_accept) fsm_next = WARMUP;
            default: fsm_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        out_seed_ready = (fsm == IDLE) || (fsm == RUN);
        out_valid      = (fsm == RUN);
    end

    // Generator state and warm-up counter. A seed load takes priority over a
    // RUN-cycle step; a zero seed is replaced by 1 since zero is a fixed point.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state   <= '0;
            counter <= '0;
        end else if (seed_accept) begin
            state   <= (in_seed == 64'd0) ? 64'd1 : in_seed;
            counter <= CNT_W'(WARMUP_CYCLES);
        end else begin
            case (fsm)
                WARMUP: begin
                    state <= xorshift64_step(state);
                    if (counter != '0) begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (in_enable) begin
                        state <= xorshift64_step(state);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
